// File: rtl/exponent_max_tree.sv
// Pipelined max-exponent finder: a log2(LANES)-level comparator tree followed by
// a shift stage that produces the winner and the per-lane alignment shift amounts.
module exponent_max_tree #(
  parameter int EXP_W = 5,
  parameter int LANES = 8,
  parameter int IDX_W = $clog2(LANES)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*EXP_W-1:0] in_exp,
  input  logic [LANES-1:0]       in_mask,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W-1:0]       out_max_exp,
  output logic [LANES-1:0]       out_sel,
  output logic [IDX_W-1:0]       out_idx,
  output logic [LANES*EXP_W-1:0] out_shift,
  output logic                   out_all_zero
);

  localparam int LVL  = $clog2(LANES);
  localparam int HALF = LANES / 2;

  // Registered candidates per level; level l only uses its first LANES>>l nodes.
  logic [EXP_W-1:0]       lvl_exp_r  [1:LVL][HALF];
  logic [IDX_W-1:0]       lvl_idx_r  [1:LVL][HALF];
  logic                   lvl_live_r [1:LVL][HALF];
  logic [LANES*EXP_W-1:0] vec_exp_r  [1:LVL];
  logic [LANES-1:0]       vec_mask_r [1:LVL];
  logic [LVL:1]           valid_r;

  logic [EXP_W-1:0]       cur_exp_s  [0:LVL][LANES];
  logic [IDX_W-1:0]       cur_idx_s  [0:LVL][LANES];
  logic                   cur_live_s [0:LVL][LANES];
  logic [EXP_W-1:0]       nxt_exp_s  [1:LVL][HALF];
  logic [IDX_W-1:0]       nxt_idx_s  [1:LVL][HALF];
  logic                   nxt_live_s [1:LVL][HALF];

  logic [EXP_W-1:0]       max_s;
  logic [LANES-1:0]       sel_s;
  logic [LANES*EXP_W-1:0] shift_s;
  logic                   stall_s;

  assign stall_s  = out_valid && !out_ready;
  assign in_ready = !stall_s;

  // Uniform view of every level's candidates: level 0 straight from the input lanes.
  always_comb begin
    for (int l = 0; l <= LVL; l++) begin
      for (int n = 0; n < LANES; n++) begin
        cur_exp_s[l][n]  = {EXP_W{1'b0}};
        cur_idx_s[l][n]  = {IDX_W{1'b0}};
        cur_live_s[l][n] = 1'b0;
      end
    end
    for (int n = 0; n < LANES; n++) begin
      cur_exp_s[0][n]  = in_exp[n*EXP_W +: EXP_W];
      cur_idx_s[0][n]  = IDX_W'(n);
      cur_live_s[0][n] = in_mask[n];
    end
    for (int l = 1; l <= LVL; l++) begin
      for (int n = 0; n < HALF; n++) begin
        cur_exp_s[l][n]  = lvl_exp_r[l][n];
        cur_idx_s[l][n]  = lvl_idx_r[l][n];
        cur_live_s[l][n] = lvl_live_r[l][n];
      end
    end
  end

  // Comparator nodes: the higher-indexed live candidate wins ties.
  always_comb begin
    for (int l = 1; l <= LVL; l++) begin
      for (int n = 0; n < HALF; n++) begin
        nxt_exp_s[l][n]  = {EXP_W{1'b0}};
        nxt_idx_s[l][n]  = {IDX_W{1'b0}};
        nxt_live_s[l][n] = 1'b0;
        if (n < (LANES >> l)) begin
          if (cur_live_s[l-1][2*n+1] &&
              (!cur_live_s[l-1][2*n] || (cur_exp_s[l-1][2*n+1] >= cur_exp_s[l-1][2*n]))) begin
            nxt_exp_s[l][n]  = cur_exp_s[l-1][2*n+1];
            nxt_idx_s[l][n]  = cur_idx_s[l-1][2*n+1];
            nxt_live_s[l][n] = 1'b1;
          end else if (cur_live_s[l-1][2*n]) begin
            nxt_exp_s[l][n]  = cur_exp_s[l-1][2*n];
            nxt_idx_s[l][n]  = cur_idx_s[l-1][2*n];
            nxt_live_s[l][n] = 1'b1;
          end else begin
            nxt_exp_s[l][n]  = {EXP_W{1'b0}};
            nxt_idx_s[l][n]  = cur_idx_s[l-1][2*n+1];
            nxt_live_s[l][n] = 1'b0;
          end
        end else begin
          nxt_live_s[l][n] = 1'b0;
        end
      end
    end
  end

  // Shift stage: decode the root and compute lane shifts against the winner.
  always_comb begin
    if (lvl_live_r[LVL][0]) begin
      max_s = lvl_exp_r[LVL][0];
      sel_s = LANES'(1'b1) << lvl_idx_r[LVL][0];
    end else begin
      max_s = {EXP_W{1'b0}};
      sel_s = {LANES{1'b0}};
    end
    for (int i = 0; i < LANES; i++) begin
      if (vec_mask_r[LVL][i]) begin
        shift_s[i*EXP_W +: EXP_W] = max_s - vec_exp_r[LVL][i*EXP_W +: EXP_W];
      end else begin
        shift_s[i*EXP_W +: EXP_W] = {EXP_W{1'b0}};
      end
    end
  end

  // Global pipeline advance; everything holds while the output is stalled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_r      <= {LVL{1'b0}};
      out_valid    <= 1'b0;
      out_max_exp  <= {EXP_W{1'b0}};
      out_sel      <= {LANES{1'b0}};
      out_idx      <= {IDX_W{1'b0}};
      out_shift    <= {(LANES*EXP_W){1'b0}};
      out_all_zero <= 1'b0;
      for (int l = 1; l <= LVL; l++) begin
        vec_exp_r[l]  <= {(LANES*EXP_W){1'b0}};
        vec_mask_r[l] <= {LANES{1'b0}};
        for (int n = 0; n < HALF; n++) begin
          lvl_exp_r[l][n]  <= {EXP_W{1'b0}};
          lvl_idx_r[l][n]  <= {IDX_W{1'b0}};
          lvl_live_r[l][n] <= 1'b0;
        end
      end
    end else if (!stall_s) begin
      valid_r[1]    <= in_valid;
      vec_exp_r[1]  <= in_exp;
      vec_mask_r[1] <= in_mask;
      for (int l = 2; l <= LVL; l++) begin
        valid_r[l]    <= valid_r[l-1];
        vec_exp_r[l]  <= vec_exp_r[l-1];
        vec_mask_r[l] <= vec_mask_r[l-1];
      end
      for (int l = 1; l <= LVL; l++) begin
        for (int n = 0; n < HALF; n++) begin
          lvl_exp_r[l][n]  <= nxt_exp_s[l][n];
          lvl_idx_r[l][n]  <= nxt_idx_s[l][n];
          lvl_live_r[l][n] <= nxt_live_s[l][n];
        end
      end
      out_valid    <= valid_r[LVL];
      out_max_exp  <= max_s;
      out_sel      <= sel_s;
      out_idx      <= lvl_idx_r[LVL][0];
      out_shift    <= shift_s;
      out_all_zero <= !lvl_live_r[LVL][0];
    end
  end

endmodule

// File: tb/tb_exponent_max_tree.sv
// Directed bench for exponent_max_tree (LANES=8, EXP_W=5) with a behavioural
// scoreboard plus literal expectations for the documented vectors.
module tb_exponent_max_tree;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [39:0] in_exp;
  logic [7:0]  in_mask;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_max_exp;
  logic [7:0]  out_sel;
  logic [2:0]  out_idx;
  logic [39:0] out_shift;
  logic        out_all_zero;

  typedef struct packed {
    logic [4:0]  mx;
    logic [7:0]  sel;
    logic [2:0]  idx;
    logic [39:0] sh;
    logic        az;
  } res_t;

  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_out    = 0;
  res_t q[$];

  exponent_max_tree #(.EXP_W(5), .LANES(8)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_exp(in_exp), .in_mask(in_mask), .out_valid(out_valid), .out_ready(out_ready),
    .out_max_exp(out_max_exp), .out_sel(out_sel), .out_idx(out_idx),
    .out_shift(out_shift), .out_all_zero(out_all_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) $display("FAIL %s: got %0h, want %0h", name, act, req);
    else n_pass++;
  endtask

  function automatic logic [39:0] pk(input int a0, a1, a2, a3, a4, a5, a6, a7);
    int a[8];
    logic [39:0] v;
    a = '{a0, a1, a2, a3, a4, a5, a6, a7};
    for (int i = 0; i < 8; i++) v[i*5 +: 5] = 5'(a[i]);
    return v;
  endfunction

  // Plain reading of the rules: largest unmasked exponent, last lane on ties.
  function automatic res_t model(input logic [39:0] e, input logic [7:0] m);
    res_t r;
    int mx = -1;
    int wi = -1;
    for (int i = 0; i < 8; i++)
      if (m[i] && int'(e[i*5 +: 5]) >= mx) begin mx = int'(e[i*5 +: 5]); wi = i; end
    r.az  = (wi < 0);
    r.mx  = (wi < 0) ? 5'd0 : 5'(mx);
    r.idx = (wi < 0) ? 3'd7 : 3'(wi);
    r.sel = (wi < 0) ? 8'd0 : (8'd1 << wi);
    for (int i = 0; i < 8; i++)
      r.sh[i*5 +: 5] = m[i] ? 5'(mx - int'(e[i*5 +: 5])) : 5'd0;
    return r;
  endfunction

  logic        have_prev = 1'b0;
  logic        prev_valid, prev_ready;
  logic [57:0] prev_out;

  // Compare process: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    res_t e;
    if (reset) begin
      q.delete();
      chk("reset_outputs", {out_valid, out_max_exp, out_sel, out_idx, out_shift, out_all_zero}, 64'd0);
      have_prev = 1'b0;
    end else begin
      chk("in_ready_rule", in_ready, !(out_valid && !out_ready));
      if (have_prev && prev_valid && !prev_ready)
        chk("stall_hold", {out_valid, out_max_exp, out_sel, out_idx, out_shift, out_all_zero}, prev_out);
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_result: got out_valid=1, want no result pending");
        end else begin
          e = q.pop_front();
          n_out++;
          chk("max_exp", out_max_exp, e.mx);
          chk("sel", out_sel, e.sel);
          chk("idx", out_idx, e.idx);
          chk("shift", out_shift, e.sh);
          chk("all_zero", out_all_zero, e.az);
        end
      end
      if (in_valid && in_ready) q.push_back(model(in_exp, in_mask));
      have_prev  = 1'b1;
      prev_valid = out_valid;
      prev_ready = out_ready;
      prev_out   = {out_valid, out_max_exp, out_sel, out_idx, out_shift, out_all_zero};
    end
  end

  task automatic send(input logic [39:0] e, input logic [7:0] m);
    chk("send_ready", in_ready, 1'b1);
    in_valid = 1'b1;
    in_exp   = e;
    in_mask  = m;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic run_vec(input string nm, input logic [39:0] e, input logic [7:0] m,
                         input logic [4:0] mx, input logic [7:0] sel, input logic [2:0] idx,
                         input logic [39:0] sh, input logic az);
    int lat = 1;
    send(e, m);
    while (!out_valid && lat < 10) begin
      @(posedge clk);
      #1 lat++;
    end
    chk({nm, "_latency"}, lat, 4);
    chk({nm, "_valid"}, out_valid, 1'b1);
    chk({nm, "_max"}, out_max_exp, mx);
    chk({nm, "_sel"}, out_sel, sel);
    chk({nm, "_idx"}, out_idx, idx);
    chk({nm, "_shift"}, out_shift, sh);
    chk({nm, "_allzero"}, out_all_zero, az);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1);
  end

  initial begin
    int base;
    int seen;
    int cyc;
    reset     = 1'b1;
    in_valid  = 1'b1;
    in_exp    = pk(3, 17, 9, 17, 2, 0, 11, 5);
    in_mask   = 8'hFF;
    out_ready = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1 chk("reset_out_valid", out_valid, 1'b0);
    end
    reset    = 1'b0;
    in_valid = 1'b0;
    #1 chk("ready_after_reset", in_ready, 1'b1);

    run_vec("full", pk(3, 17, 9, 17, 2, 0, 11, 5), 8'hFF,
            5'd17, 8'b0000_1000, 3'd3, pk(14, 0, 8, 0, 15, 17, 6, 12), 1'b0);
    run_vec("masked", pk(3, 17, 9, 17, 2, 0, 11, 5), 8'b1111_0101,
            5'd11, 8'b0100_0000, 3'd6, pk(8, 0, 2, 0, 9, 11, 0, 6), 1'b0);
    run_vec("none", pk(3, 17, 9, 17, 2, 0, 11, 5), 8'h00,
            5'd0, 8'h00, 3'd7, 40'd0, 1'b1);
    run_vec("all_tie", pk(20, 20, 20, 20, 20, 20, 20, 20), 8'hFF,
            5'd20, 8'h80, 3'd7, 40'd0, 1'b0);
    run_vec("lane0_max", pk(31, 0, 0, 0, 0, 0, 0, 0), 8'hFF,
            5'd31, 8'h01, 3'd0, pk(0, 31, 31, 31, 31, 31, 31, 31), 1'b0);
    run_vec("single_zero", pk(7, 9, 30, 1, 4, 0, 12, 8), 8'h20,
            5'd0, 8'h20, 3'd5, 40'd0, 1'b0);

    // Six back-to-back vectors, then a five-cycle downstream stall.
    base = n_out;
    for (int k = 0; k < 6; k++)
      send(pk(k, 2*k, 31-k, 5, k+9, 3*k, 1, 30-2*k), 8'hFF ^ 8'(1 << k));
    cyc = 0;
    while (!out_valid && cyc < 10) begin @(posedge clk); #1 cyc++; end
    out_ready = 1'b0;
    repeat (5) begin
      @(posedge clk);
      #1 chk("stall_in_ready", in_ready, 1'b0);
    end
    out_ready = 1'b1;
    cyc = 0;
    while (n_out < base + 6 && cyc < 20) begin @(posedge clk); #1 cyc++; end
    repeat (3) @(posedge clk);
    #1 chk("stream_count", n_out - base, 6);

    // Reset with one result at the output and three vectors behind it.
    for (int k = 0; k < 4; k++) send(pk(k+1, 4, 8, 12, 16, 20, 24, 28-k), 8'hFF);
    chk("pre_reset_valid", out_valid, 1'b1);
    reset = 1'b1;
    #1 chk("reset_drops_valid", out_valid, 1'b0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    seen = 0;
    repeat (10) begin
      @(posedge clk);
      #1 if (out_valid) seen++;
    end
    chk("no_stale_after_reset", seen, 0);

    run_vec("post_reset", pk(3, 17, 9, 17, 2, 0, 11, 5), 8'hFF,
            5'd17, 8'b0000_1000, 3'd3, pk(14, 0, 8, 0, 15, 17, 6, 12), 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
